// File: rtl/keypad_scanner_pkg.sv
// Shared constants for the keypad scanner: FSM encoding, column dwell and key code width.
package keypad_scanner_pkg;

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  localparam int unsigned DWELL_CYCLES = 4;
  localparam int unsigned KEY_CODE_W   = 4;

  // Index of the lowest-numbered active-low row; callers only use it when some row is low.
  function automatic logic [1:0] lowest_low(input logic [3:0] rows);
    logic [1:0] idx;
    casez (rows)
      4'b???0: idx = 2'd0;
      4'b??01: idx = 2'd1;
      4'b?011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_row_sync.sv
// Two-flop synchronizer for the asynchronous, pulled-up row sense lines.
module row_sync #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Idle level is all-ones so a reset never looks like a pressed key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= {WIDTH{1'b1}};
      sync_r <= {WIDTH{1'b1}};
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: walks the columns, debounces one press and its release, no rollover.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                  div_clock,
  input  logic                  reset,
  input  logic [3:0]            row,
  output logic [3:0]            col,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_valid,
  output logic                  key_held
);

  localparam logic [3:0] DB_LIMIT   = 4'(DEBOUNCE_CYCLES);
  localparam logic [1:0] DWELL_LAST = 2'(DWELL_CYCLES - 1);

  logic [3:0]            row_s;
  logic [1:0]            state_r, state_nxt_s;
  logic [1:0]            col_idx_r, col_idx_nxt_s;
  logic [1:0]            dwell_r, dwell_nxt_s;
  logic [1:0]            row_idx_r, row_idx_nxt_s;
  logic [3:0]            cnt_r, cnt_nxt_s, cnt_inc_s;
  logic [3:0]            col_r, col_nxt_s;
  logic [KEY_CODE_W-1:0] key_code_r, key_code_nxt_s;
  logic                  key_valid_r, key_valid_nxt_s;
  logic                  key_held_r, key_held_nxt_s;
  logic                  row_bit_s;

  row_sync #(.WIDTH(4)) u_row_sync (
    .clk   (div_clock),
    .rst_n (reset),
    .d     (row),
    .q     (row_s)
  );

  // Next-state logic for scanning, press debounce, hold and release debounce.
  always_comb begin
    state_nxt_s     = state_r;
    col_idx_nxt_s   = col_idx_r;
    dwell_nxt_s     = dwell_r;
    row_idx_nxt_s   = row_idx_r;
    cnt_nxt_s       = cnt_r;
    key_code_nxt_s  = key_code_r;
    key_valid_nxt_s = 1'b0;
    key_held_nxt_s  = key_held_r;
    row_bit_s       = row_s[row_idx_r];
    cnt_inc_s       = (cnt_r == 4'hF) ? cnt_r : cnt_r + 4'd1;

    case (state_r)
      ST_SCAN: begin
        if (dwell_r == DWELL_LAST) begin
          dwell_nxt_s = 2'd0;
          if (row_s != 4'hF) begin
            row_idx_nxt_s = lowest_low(row_s);
            cnt_nxt_s     = 4'd0;
            state_nxt_s   = ST_DEBOUNCE;
          end else begin
            col_idx_nxt_s = col_idx_r + 2'd1;
          end
        end else begin
          dwell_nxt_s = dwell_r + 2'd1;
        end
      end
      ST_DEBOUNCE: begin
        if (!row_bit_s) begin
          cnt_nxt_s = cnt_inc_s;
          if (cnt_inc_s == DB_LIMIT) begin
            key_code_nxt_s  = {row_idx_r, col_idx_r};
            key_valid_nxt_s = 1'b1;
            key_held_nxt_s  = 1'b1;
            state_nxt_s     = ST_HELD;
          end else begin
            state_nxt_s = ST_DEBOUNCE;
          end
        end else begin
          // Bounce during press: give up on this column and keep scanning.
          state_nxt_s   = ST_SCAN;
          col_idx_nxt_s = col_idx_r + 2'd1;
          dwell_nxt_s   = 2'd0;
        end
      end
      ST_HELD: begin
        if (row_bit_s) begin
          cnt_nxt_s   = 4'd0;
          state_nxt_s = ST_RELEASE;
        end else begin
          state_nxt_s = ST_HELD;
        end
      end
      ST_RELEASE: begin
        if (row_bit_s) begin
          cnt_nxt_s = cnt_inc_s;
          if (cnt_inc_s == DB_LIMIT) begin
            key_held_nxt_s = 1'b0;
            state_nxt_s    = ST_SCAN;
            col_idx_nxt_s  = 2'd0;
            dwell_nxt_s    = 2'd0;
          end else begin
            state_nxt_s = ST_RELEASE;
          end
        end else begin
          state_nxt_s = ST_HELD;
        end
      end
      default: begin
        state_nxt_s   = ST_SCAN;
        col_idx_nxt_s = 2'd0;
        dwell_nxt_s   = 2'd0;
        cnt_nxt_s     = 4'd0;
      end
    endcase

    col_nxt_s = ~(4'b0001 << col_idx_nxt_s);
  end

  // State and output registers.
  always_ff @(posedge div_clock or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_SCAN;
      col_idx_r   <= 2'd0;
      dwell_r     <= 2'd0;
      row_idx_r   <= 2'd0;
      cnt_r       <= 4'd0;
      col_r       <= 4'b1110;
      key_code_r  <= {KEY_CODE_W{1'b0}};
      key_valid_r <= 1'b0;
      key_held_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      col_idx_r   <= col_idx_nxt_s;
      dwell_r     <= dwell_nxt_s;
      row_idx_r   <= row_idx_nxt_s;
      cnt_r       <= cnt_nxt_s;
      col_r       <= col_nxt_s;
      key_code_r  <= key_code_nxt_s;
      key_valid_r <= key_valid_nxt_s;
      key_held_r  <= key_held_nxt_s;
    end
  end

  assign col       = col_r;
  assign key_code  = key_code_r;
  assign key_valid = key_valid_r;
  assign key_held  = key_held_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a switch-matrix model drives row from col and pressed keys.
module tb_keypad_scanner;

  localparam int DB = 4;

  logic        div_clock = 1'b0;
  logic        reset;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] pressed;  // bit 4*r+c set while key (r,c) is physically down

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int mon_code;

  always #5 div_clock = ~div_clock;

  // A pressed key pulls its row low only while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[4*r+c] && !col[c]) row[r] = 1'b0;
  end

  keypad_scanner #(.DEBOUNCE_CYCLES(DB)) dut (
    .div_clock (div_clock),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge div_clock);
  endtask

  // Monitor: every key_valid pulse must match the oldest expected key.
  always @(negedge div_clock) begin
    if (reset) begin
      check("col_one_cold", {31'd0, (col == 4'b1110 || col == 4'b1101 ||
                                     col == 4'b1011 || col == 4'b0111)}, 32'd1);
      if (key_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", {31'd0, key_valid}, 32'd0);
        end else begin
          mon_code = exp_q.pop_front();
          check("key_code", {28'd0, key_code}, mon_code);
          check("held_with_valid", {31'd0, key_held}, 32'd1);
        end
      end
    end
  end

  // One press/hold/release episode; the accepted key is the lowest pressed row in the column.
  task automatic episode(input int r1, input int c1, input bit dbl, input int r2,
                         input bit roll, input int rr, input int rc, input bit bounce);
    logic [15:0] keys;
    int          code;
    keys = 16'd0;
    keys[4*r1+c1] = 1'b1;
    code = 4*r1 + c1;
    if (dbl && r2 != r1) begin
      keys[4*r2+c1] = 1'b1;
      if (r2 < r1) code = 4*r2 + c1;
    end
    cycles($urandom_range(0, 8));
    if (bounce) begin
      pressed = keys;
      cycles($urandom_range(1, DB - 1));
      pressed = 16'd0;
      cycles(1);
    end
    pressed = keys;
    exp_q.push_back(code);
    cycles(40);
    if (roll && !keys[4*rr+rc]) begin
      pressed = keys | (16'd1 << (4*rr + rc));
      cycles(10);
      pressed = keys;
      cycles(6);
    end
    check("held_before_release", {31'd0, key_held}, 32'd1);
    pressed = 16'd0;
    if (bounce) begin
      cycles($urandom_range(1, DB - 1));
      pressed = keys;
      cycles($urandom_range(1, 3));
      pressed = 16'd0;
      check("held_through_bounce", {31'd0, key_held}, 32'd1);
    end
    cycles(DB + 10);
    check("held_after_release", {31'd0, key_held}, 32'd0);
    check("code_kept_after_release", {28'd0, key_code}, code);
  endtask

  initial begin
    logic [3:0] one;
    logic [3:0] seen;
    int         r;
    one     = 4'b0001;
    reset   = 1'b0;
    pressed = 16'd0;
    cycles(3);
    check("rst_col", {28'd0, col}, 32'he);
    check("rst_code", {28'd0, key_code}, 32'd0);
    check("rst_valid", {31'd0, key_valid}, 32'd0);
    check("rst_held", {31'd0, key_held}, 32'd0);

    // Idle scan: after j rising edges the driven column is (j/4)%4.
    reset = 1'b1;
    for (int j = 1; j <= 64; j++) begin
      @(negedge div_clock);
      check("idle_col", {28'd0, col}, {28'd0, ~(one << ((j / 4) % 4))});
      check("idle_valid", {31'd0, key_valid}, 32'd0);
    end

    episode(2, 1, 1'b0, 0, 1'b0, 0, 0, 1'b1);
    episode(1, 0, 1'b1, 3, 1'b1, 2, 2, 1'b0);

    // Short glitches are rejected and scanning carries on.
    for (int len = 1; len < DB; len++) begin
      pressed = 16'd1 << $urandom_range(0, 15);
      cycles(len);
      pressed = 16'd0;
      cycles(24);
      check("glitch_held", {31'd0, key_held}, 32'd0);
      seen = 4'd0;
      for (int k = 0; k < 16; k++) begin
        @(negedge div_clock);
        seen = seen | ~col;
      end
      check("glitch_scan_resumes", {28'd0, seen}, 32'hf);
    end

    for (int n = 0; n < 14; n++) begin
      episode($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Reset during press debounce aborts; the still-held key is accepted afterwards.
    for (int n = 0; n < 3; n++) begin
      r = $urandom_range(0, 3);
      reset = 1'b0;
      cycles(2);
      reset   = 1'b1;
      pressed = 16'd1 << (4*r);
      cycles(5);
      reset = 1'b0;
      #1;
      check("midrst_col", {28'd0, col}, 32'he);
      check("midrst_code", {28'd0, key_code}, 32'd0);
      check("midrst_valid", {31'd0, key_valid}, 32'd0);
      check("midrst_held", {31'd0, key_held}, 32'd0);
      cycles(2);
      reset = 1'b1;
      exp_q.push_back(4*r);
      cycles(40);
      check("rst_rehold", {31'd0, key_held}, 32'd1);
      pressed = 16'd0;
      cycles(DB + 10);
      check("rst_release", {31'd0, key_held}, 32'd0);
    end

    check("all_expected_seen", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
